// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM states shared by alu_pipe_seq.
// BUSY exists only when ALU_MUL_EN is defined.
package alu_pkg;
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_SHL = 4'h6;
   localparam logic [3:0] OP_SHR = 4'h7;
   localparam logic [3:0] OP_CMP = 4'h8;
   localparam logic [3:0] OP_EQ  = 4'h9;
   localparam logic [3:0] OP_SRA = 4'hA;
   localparam logic [3:0] OP_SLT = 4'hB;
   localparam logic [3:0] OP_MUL = 4'hC;
   localparam logic [3:0] OP_ROL = 4'hD;
   localparam int FLG_CARRY = 0;
   localparam int FLG_ZERO  = 1;
   localparam int FLG_NEG   = 2;
   localparam int FLG_OVF   = 3;
   localparam int FLG_ERR   = 4;
`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif
endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier; one partial product per clock,
// done pulses one cycle after the last of WIDTH steps.
module alu_seq_mul #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);
   localparam int CW = $clog2(WIDTH);
   logic [2*WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic [WIDTH:0]     sum;
   logic               last;
   always_comb begin
      last   = cnt_q == CW'(WIDTH - 1);
      // upper half accumulates the multiplicand; lower half shifts out multiplier bits
      sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
      p_d    = busy_q ? {sum, p_q[WIDTH-1:1]} : p_q;
      a_d    = a_q;
      cnt_d  = busy_q ? cnt_q + 1'b1 : cnt_q;
      busy_d = busy_q && !last;
      done_d = busy_q && last;
      if (start) begin
         p_d    = {{WIDTH{1'b0}}, b};
         a_d    = a;
         cnt_d  = '0;
         busy_d = 1'b1;
         done_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         p_q    <= '0;
         a_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         p_q    <= p_d;
         a_q    <= a_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   assign done = done_q;
   assign prod = p_q;
endmodule

// File: rtl/alu_pipe_seq.sv
// alu_pipe_seq: registered ALU behind valid/ready handshakes, flags {err,ovf,neg,zero,carry}.
// Define ALU_MUL_EN to add the iterative multiplier (opcode 1100) and the BUSY state.
module alu_pipe_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic [4:0]       flags
);
   localparam int SHW = $clog2(WIDTH);
   state_t             state_q, state_d;
   logic [WIDTH-1:0]   res_q, res_d, op_res;
   logic [4:0]         flg_q, flg_d, op_flg;
   logic               op_carry, op_ovf, op_err;
   logic [WIDTH:0]     sum, dif;
   logic [2*WIDTH-1:0] rol;
   logic [SHW-1:0]     sh;
   logic               accept;
`ifdef ALU_MUL_EN
   logic               mul_start, mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mul_start),
      .a     (a),
      .b     (b),
      .done  (mul_done),
      .prod  (mul_prod)
   );
`endif
   assign sh        = b[SHW-1:0];
   assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
   assign out_valid = state_q == DONE;
   assign accept    = in_valid && in_ready;
   assign alu_out   = res_q;
   assign flags     = flg_q;
   always_comb begin
      sum      = {1'b0, a} + {1'b0, b};
      dif      = {1'b0, a} - {1'b0, b};
      rol      = {a, a} << sh;
      op_res   = '0;
      op_carry = 1'b0;
      op_ovf   = 1'b0;
      op_err   = 1'b0;
      case (alu_sel)
         OP_ADD: begin
            op_res   = sum[WIDTH-1:0];
            op_carry = sum[WIDTH];
            op_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            op_res   = dif[WIDTH-1:0];
            op_carry = dif[WIDTH];
            op_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: op_res = a & b;
         OP_OR:  op_res = a | b;
         OP_XOR: op_res = a ^ b;
         OP_NOT: op_res = ~a;
         OP_SHL: op_res = a << sh;
         OP_SHR: op_res = a >> sh;
         OP_CMP: op_res = (a > b) ? WIDTH'(2) : WIDTH'(1);
         OP_EQ:  op_res = WIDTH'(a == b);
         OP_SRA: op_res = $signed(a) >>> sh;
         OP_SLT: op_res = WIDTH'($signed(a) < $signed(b));
         OP_ROL: op_res = rol[2*WIDTH-1:WIDTH];
         default: op_err = 1'b1;
      endcase
      op_flg            = '0;
      op_flg[FLG_CARRY] = op_carry;
      op_flg[FLG_ZERO]  = op_res == '0;
      op_flg[FLG_NEG]   = op_res[WIDTH-1];
      op_flg[FLG_OVF]   = op_ovf;
      op_flg[FLG_ERR]   = op_err;
   end
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      flg_d   = flg_q;
`ifdef ALU_MUL_EN
      mul_start = 1'b0;
`endif
      case (state_q)
`ifdef ALU_MUL_EN
         BUSY: if (mul_done) begin
            state_d          = DONE;
            res_d            = mul_prod[WIDTH-1:0];
            flg_d            = '0;
            flg_d[FLG_CARRY] = |mul_prod[2*WIDTH-1:WIDTH];
            flg_d[FLG_ZERO]  = mul_prod[WIDTH-1:0] == '0;
            flg_d[FLG_NEG]   = mul_prod[WIDTH-1];
         end
`endif
         default: if (accept) begin
`ifdef ALU_MUL_EN
            if (alu_sel == OP_MUL) begin
               mul_start = 1'b1;
               state_d   = BUSY;
            end else
`endif
            begin
               state_d = DONE;
               res_d   = op_res;
               flg_d   = op_flg;
            end
         end else if (state_q == DONE && out_ready) state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         res_q   <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
      end
endmodule

// File: tb/tb_alu_pipe_seq.sv
// tb_alu_pipe_seq: directed self-checking bench for alu_pipe_seq (WIDTH=32),
// expectations follow ALU_MUL_EN when it is defined.
module tb_alu_pipe_seq;
   import alu_pkg::*;
   localparam int W = 32;
   typedef struct {
      logic [3:0]   s;
      logic [W-1:0] x, y, r;
      logic [4:0]   f;
   } vec_t;
   logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
   logic         in_ready, out_valid;
   logic [W-1:0] a = '0, b = '0, alu_out;
   logic [3:0]   alu_sel = '0;
   logic [4:0]   flags;
   int           vecs = 0, errs = 0;
   vec_t         tv[23];

   alu_pipe_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .alu_sel   (alu_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_out   (alu_out),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   // present an op and return #1 after the edge that accepted it
   task automatic issue(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
      bit acc = 0;
      alu_sel  = s;
      a        = x;
      b        = y;
      in_valid = 1;
      for (int n = 0; n < 100 && !acc; n++) begin
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      vecs++;
      if (!acc) begin
         errs++;
         $display("FAIL issue: in_ready never seen for opcode %h", s);
      end
   endtask

   task automatic test_reset;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errs++;
         $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      end
      vecs++;
      if (alu_out !== '0 || flags !== 5'b0) begin
         errs++;
         $display("FAIL reset_regs: alu_out=%h flags=%b, want 0/00000", alu_out, flags);
      end
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_cycle;
      tv = '{
         '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b00011},
         '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01100},
         '{OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b01000},
         '{OP_SUB, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 5'b00101},
         '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b00100},
         '{OP_OR,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 5'b00000},
         '{OP_XOR, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 5'b00010},
         '{OP_NOT, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 5'b00100},
         '{OP_SHL, 32'h12345678, 32'h00000000, 32'h12345678, 5'b00000},
         '{OP_SHL, 32'h12345678, 32'h00000021, 32'h2468ACF0, 5'b00000},
         '{OP_SHR, 32'hF0000000, 32'h00000004, 32'h0F000000, 5'b00000},
         '{OP_SRA, 32'hF0000000, 32'h00000004, 32'hFF000000, 5'b00100},
         '{OP_SRA, 32'h70000000, 32'h00000004, 32'h07000000, 5'b00000},
         '{OP_ROL, 32'h80000001, 32'h00000001, 32'h00000003, 5'b00000},
         '{OP_ROL, 32'h12345678, 32'h00000004, 32'h23456781, 5'b00000},
         '{OP_CMP, 32'h00000005, 32'h00000003, 32'h00000002, 5'b00000},
         '{OP_CMP, 32'h00000005, 32'h00000005, 32'h00000001, 5'b00000},
         '{OP_EQ,  32'h00000007, 32'h00000007, 32'h00000001, 5'b00000},
         '{OP_EQ,  32'h00000007, 32'h00000008, 32'h00000000, 5'b00010},
         '{OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000},
         '{OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 5'b00010},
         '{4'hF,   32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b10010},
         '{4'hE,   32'h00000001, 32'h00000001, 32'h00000000, 5'b10010}
      };
      for (int i = 0; i < 23; i++) begin
         issue(tv[i].s, tv[i].x, tv[i].y);
         vecs++;
         if (out_valid !== 1'b1) begin
            errs++;
            $display("FAIL op%0d_latency: out_valid=%b one cycle after accept, want 1", i, out_valid);
         end
         vecs++;
         if (alu_out !== tv[i].r || flags !== tv[i].f) begin
            errs++;
            $display("FAIL op%0d_sel%h: got %h/%b, want %h/%b", i, tv[i].s, alu_out, flags, tv[i].r, tv[i].f);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      out_ready = 0;
      issue(OP_ADD, 32'h1, 32'h2);
      alu_sel  = OP_XOR;
      a        = 32'hF0F0F0F0;
      b        = 32'hFFFFFFFF;
      in_valid = 1;
      for (int k = 0; k < 4; k++) begin
         vecs++;
         if (out_valid !== 1'b1 || alu_out !== 32'h3 || flags !== 5'b0 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL hold%0d: out_valid=%b alu_out=%h flags=%b in_ready=%b, want 1/3/00000/0", k, out_valid, alu_out, flags, in_ready);
         end
         if (k < 3) begin
            @(posedge clk);
            #1;
         end
      end
      out_ready = 1;
      #1;
      vecs++;
      if (in_ready !== 1'b1) begin
         errs++;
         $display("FAIL b2b_ready: in_ready=%b, want 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 0;
      vecs++;
      if (out_valid !== 1'b1 || alu_out !== 32'h0F0F0F0F || flags !== 5'b0) begin
         errs++;
         $display("FAIL b2b_next: out_valid=%b alu_out=%h flags=%b, want 1/0F0F0F0F/00000", out_valid, alu_out, flags);
      end
      @(posedge clk);
      #1;
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errs++;
         $display("FAIL b2b_idle: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_mul;
`ifdef ALU_MUL_EN
      int  n;
      bit  busy_ok;
      logic [W-1:0] mx[2] = '{32'h00010000, 32'hFFFFFFFF};
      logic [W-1:0] mr[2] = '{32'h00000000, 32'h00000001};
      logic [4:0]   mf[2] = '{5'b00011, 5'b00001};
      for (int i = 0; i < 2; i++) begin
         issue(OP_MUL, mx[i], mx[i]);
         n       = 0;
         busy_ok = 1;
         while (out_valid !== 1'b1 && n < 100) begin
            if (in_ready !== 1'b0) busy_ok = 0;
            @(posedge clk);
            #1;
            n++;
         end
         vecs++;
         if (n != W + 1) begin
            errs++;
            $display("FAIL mul%0d_latency: out_valid after %0d cycles, want %0d", i, n, W + 1);
         end
         vecs++;
         if (!busy_ok) begin
            errs++;
            $display("FAIL mul%0d_busy_ready: in_ready=1 seen during BUSY, want 0");
         end
         vecs++;
         if (alu_out !== mr[i] || flags !== mf[i]) begin
            errs++;
            $display("FAIL mul%0d_result: got %h/%b, want %h/%b", i, alu_out, flags, mr[i], mf[i]);
         end
         @(posedge clk);
         #1;
      end
`else
      issue(OP_MUL, 32'h00010000, 32'h00010000);
      vecs++;
      if (out_valid !== 1'b1 || alu_out !== 32'h0 || flags !== 5'b10010) begin
         errs++;
         $display("FAIL mul_illegal: out_valid=%b alu_out=%h flags=%b, want 1/00000000/10010", out_valid, alu_out, flags);
      end
      @(posedge clk);
      #1;
`endif
   endtask

   task automatic test_reset_mid;
      bit stale = 0;
      out_ready = 0;
      issue(OP_ADD, 32'h5, 32'h6);
      @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_out !== '0 || flags !== 5'b0) begin
         errs++;
         $display("FAIL rst_hold: out_valid=%b in_ready=%b alu_out=%h flags=%b, want 0/1/0/00000", out_valid, in_ready, alu_out, flags);
      end
      #1;
      rst_n     = 1;
      out_ready = 1;
`ifdef ALU_MUL_EN
      issue(OP_MUL, 32'h3, 32'h5);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errs++;
         $display("FAIL rst_busy: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      end
      #1;
      rst_n = 1;
`endif
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) stale = 1;
      end
      vecs++;
      if (stale) begin
         errs++;
         $display("FAIL rst_stale: out_valid=1 after reset, want 0");
      end
   endtask

   initial begin
      test_reset;
      test_single_cycle;
      test_back_to_back;
      test_mul;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
